// File: rtl/quad_flit_serializer_if.sv
// Quad-in / flit-out handshake bundle for quad_flit_serializer.
interface quad_flit_serializer_if #(
  parameter int unsigned FLIT_W = 10
);
  logic [FLIT_W-1:0] nty;
  logic [FLIT_W-1:0] sty;
  logic [FLIT_W-1:0] ety;
  logic [FLIT_W-1:0] wty;
  logic [3:0]        lane_vld;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] flit_out;
  logic [1:0]        flit_port;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        occupancy;

  modport master (
    output nty, sty, ety, wty, lane_vld, in_valid, out_ready,
    input  in_ready, flit_out, flit_port, out_valid, occupancy
  );

  modport slave (
    input  nty, sty, ety, wty, lane_vld, in_valid, out_ready,
    output in_ready, flit_out, flit_port, out_valid, occupancy
  );
endinterface

// File: rtl/quad_flit_serializer.sv
// Buffers 4-lane quads in a small circular FIFO and emits their valid lanes
// one flit per cycle in N, S, E, W order.
module quad_flit_serializer #(
  parameter int unsigned FLIT_W = 10,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  quad_flit_serializer_if.slave  bus
);
  localparam int unsigned LANES = 4;
  localparam int unsigned PTR_W = (DEPTH > 2) ? 2 : 1;

  logic [LANES-1:0][FLIT_W-1:0] data_q [DEPTH];
  logic [LANES-1:0][FLIT_W-1:0] data_d [DEPTH];
  logic [LANES-1:0]             mask_q [DEPTH];
  logic [LANES-1:0]             mask_d [DEPTH];
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [1:0]                   occ_q, occ_d;

  logic [LANES-1:0] head_mask_c;
  logic [LANES-1:0] head_rest_c;
  logic [1:0]       sel_c;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             push_c;
  logic             xfer_c;
  logic             pop_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Head lane pick (lowest pending bit) and handshake qualification.
  always_comb begin
    head_mask_c = mask_q[rd_ptr_q];
    sel_c       = '0;
    for (int i = int'(LANES) - 1; i >= 0; i--) begin
      if (head_mask_c[i]) sel_c = 2'(i);
    end
    head_rest_c = head_mask_c & ~(LANES'(1) << sel_c);
    in_ready_c  = occ_q < 2'(DEPTH);
    out_valid_c = occ_q != 2'd0;
    push_c      = bus.in_valid && in_ready_c && (bus.lane_vld != 4'd0);
    xfer_c      = out_valid_c && bus.out_ready;
    pop_c       = xfer_c && (head_rest_c == '0);
  end

  // Next-state: clear served lane, retire empty head, append new quad.
  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (xfer_c) begin
      mask_d[rd_ptr_q] = head_rest_c;
      if (pop_c) rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (push_c) begin
      data_d[wr_ptr_q] = {bus.wty, bus.ety, bus.sty, bus.nty};
      mask_d[wr_ptr_q] = bus.lane_vld;
      wr_ptr_d         = next_ptr(wr_ptr_q);
    end
    case ({push_c, pop_c})
      2'b10:   occ_d = 2'(occ_q + 2'd1);
      2'b01:   occ_d = 2'(occ_q - 2'd1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mask_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      mask_q   <= mask_d;
    end
  end

  // Payload storage carries no reset; validity lives in the masks.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.flit_out  = out_valid_c ? data_q[rd_ptr_q][sel_c] : '0;
  assign bus.flit_port = out_valid_c ? sel_c : 2'd0;
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_quad_flit_serializer.sv
// Self-checking bench: directed scenarios plus random traffic against a flit-queue model.
module tb_quad_flit_serializer;
  localparam int unsigned FLIT_W = 10;
  localparam int unsigned DEPTH  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  quad_flit_serializer_if #(.FLIT_W(FLIT_W)) bus ();

  quad_flit_serializer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: pending flits in output order, with a flag marking each quad's last flit.
  logic [FLIT_W-1:0] m_data [$];
  logic [1:0]        m_port [$];
  bit                m_last [$];
  int                m_nq = 0;
  bit                accepted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit iv, input logic [3:0] lv,
                       input logic [FLIT_W-1:0] n, s, e, w, input bit ordy);
    bit push;
    bit xfer;
    logic [FLIT_W-1:0] q [4];
    rst           = r;
    bus.in_valid  = iv;
    bus.lane_vld  = lv;
    bus.nty       = n;
    bus.sty       = s;
    bus.ety       = e;
    bus.wty       = w;
    bus.out_ready = ordy;
    chk("in_ready",  32'(bus.in_ready),  32'(m_nq < int'(DEPTH)));
    chk("out_valid", 32'(bus.out_valid), 32'(m_nq != 0));
    chk("flit_out",  32'(bus.flit_out),  (m_nq != 0) ? 32'(m_data[0]) : 32'd0);
    chk("flit_port", 32'(bus.flit_port), (m_nq != 0) ? 32'(m_port[0]) : 32'd0);
    chk("occupancy", 32'(bus.occupancy), 32'(m_nq));
    accepted = iv && (m_nq < int'(DEPTH));
    push     = accepted && (lv != 4'd0);
    xfer     = (m_nq != 0) && ordy;
    @(posedge clk);
    if (r) begin
      m_data.delete();
      m_port.delete();
      m_last.delete();
      m_nq = 0;
    end else begin
      if (xfer) begin
        void'(m_data.pop_front());
        void'(m_port.pop_front());
        if (m_last.pop_front()) m_nq--;
      end
      if (push) begin
        q = '{n, s, e, w};
        for (int i = 0; i < 4; i++) begin
          if (lv[i]) begin
            m_data.push_back(q[i]);
            m_port.push_back(2'(i));
            m_last.push_back(4'(lv >> (i + 1)) == 4'd0);
          end
        end
        m_nq++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit ordy, input int cnt);
    for (int i = 0; i < cnt; i++) cycle(1'b0, 1'b0, 4'd0, '0, '0, '0, '0, ordy);
  endtask

  initial begin
    bit done;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.lane_vld = '0; bus.out_ready = 1'b0;
    bus.nty = '0; bus.sty = '0; bus.ety = '0; bus.wty = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cycle(1'b1, 1'b1, 4'hF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 1'b1);
    idle(1'b1, 1);

    // Single full quad drains on four consecutive cycles.
    cycle(1'b0, 1'b1, 4'hF, 10'h001, 10'h002, 10'h003, 10'h004, 1'b1);
    idle(1'b1, 5);

    // Sparse lanes, then an all-invalid quad that must vanish.
    cycle(1'b0, 1'b1, 4'b1010, 10'h000, 10'h155, 10'h000, 10'h2AA, 1'b1);
    idle(1'b1, 3);
    cycle(1'b0, 1'b1, 4'b0000, 10'h111, 10'h222, 10'h333, 10'h044, 1'b1);
    idle(1'b1, 2);

    // Fill under backpressure; fourth quad waits, then order holds across wrap.
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, 4'hF, 10'(16*k+1), 10'(16*k+2), 10'(16*k+3), 10'(16*k+4), 1'b0);
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, 4'b0101, 10'h0A1, 10'h0A2, 10'h0A3, 10'h0A4, 1'b0);
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      cycle(1'b0, 1'b1, 4'b0101, 10'h0A1, 10'h0A2, 10'h0A3, 10'h0A4, 1'b1);
      done = accepted;
    end
    if (!done) chk("q4_accept_timeout", 32'd0, 32'd1);
    idle(1'b1, 14);

    // Push lands on the head's final lane: occupancy stays 1, no bubble.
    cycle(1'b0, 1'b1, 4'hF, 10'h101, 10'h102, 10'h103, 10'h104, 1'b1);
    idle(1'b1, 3);
    cycle(1'b0, 1'b1, 4'b1001, 10'h201, 10'h000, 10'h000, 10'h204, 1'b1);
    idle(1'b1, 4);

    // Reset mid-drain with two quads queued behind the head.
    cycle(1'b0, 1'b1, 4'hF, 10'h301, 10'h302, 10'h303, 10'h304, 1'b1);
    cycle(1'b0, 1'b1, 4'hF, 10'h311, 10'h312, 10'h313, 10'h314, 1'b1);
    cycle(1'b0, 1'b1, 4'hF, 10'h321, 10'h322, 10'h323, 10'h324, 1'b1);
    cycle(1'b1, 1'b1, 4'hF, 10'h331, 10'h332, 10'h333, 10'h334, 1'b1);
    cycle(1'b0, 1'b1, 4'b0110, 10'h000, 10'h341, 10'h342, 10'h000, 1'b1);
    idle(1'b1, 4);

    // Random traffic with occasional resets.
    for (int t = 0; t < 600; t++) begin
      cycle(($urandom % 60) == 0, ($urandom % 4) != 0, 4'($urandom),
            FLIT_W'($urandom), FLIT_W'($urandom), FLIT_W'($urandom), FLIT_W'($urandom),
            ($urandom % 3) != 0);
    end
    idle(1'b1, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/quad_flit_serializer.md
QUAD_FLIT_SERIALIZER -- requirements
Module: quad_flit_serializer

Interface
REQ-001 Parameter FLIT_W, default 10: width of one flit.
REQ-002 Parameter DEPTH, default 3: number of quad entries in the buffer; valid range 2..3.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 nty  input  FLIT_W: north-lane flit of the incoming quad.
REQ-006 sty  input  FLIT_W: south-lane flit of the incoming quad.
REQ-007 ety  input  FLIT_W: east-lane flit of the incoming quad.
REQ-008 wty  input  FLIT_W: west-lane flit of the incoming quad.
REQ-009 lane_vld  input  4: per-lane valid; bit0=N, bit1=S, bit2=E, bit3=W.
REQ-010 in_valid  input  1: incoming quad is offered.
REQ-011 in_ready  output  1: buffer can accept a quad this cycle.
REQ-012 flit_out  output  FLIT_W: flit currently presented.
REQ-013 flit_port  output  2: source lane of flit_out; 0=N, 1=S, 2=E, 3=W.
REQ-014 out_valid  output  1: flit_out and flit_port are valid.
REQ-015 out_ready  input  1: consumer accepts the presented flit.
REQ-016 occupancy  output  2: number of quads held, 0..DEPTH.

Function
REQ-017 Buffer: circular FIFO of DEPTH entries; each entry holds 4 flits plus a 4-bit pending mask; rd/wr pointers wrap DEPTH-1 -> 0.
REQ-018 in_ready = (occupancy < DEPTH); derived from registered state only, with no combinational path from out_ready.
REQ-019 Push occurs when in_valid && in_ready && lane_vld != 0: all four flits and mask = lane_vld are stored at the write pointer, and the write pointer advances.
REQ-020 A quad with in_valid && in_ready && lane_vld == 0 is consumed and discarded; no state changes.
REQ-021 out_valid = (occupancy != 0).
REQ-022 Head selection: the lowest set bit of the head entry's pending mask selects the lane; flit_out and flit_port present that lane. Lanes are served in order N, S, E, W and cleared lanes are skipped with no idle cycle.
REQ-023 Transfer occurs when out_valid && out_ready: the selected bit is cleared in the head mask.
REQ-024 If a transfer clears the last pending bit, the entry is popped in the same edge and the read pointer advances.
REQ-025 When out_valid == 0, flit_out = 0 and flit_port = 0.
REQ-026 Latency: a quad pushed at edge k into an empty buffer gives out_valid = 1 after edge k, so its first flit can transfer at edge k+1.
REQ-027 There is no bypass: a push into an empty buffer is never presented in the same cycle.
REQ-028 Simultaneous push and pop in one edge leaves occupancy unchanged, and both pointers advance.
REQ-029 When full (occupancy == DEPTH), in_ready = 0 even if a pop occurs in the same cycle.
REQ-030 out_valid && !out_ready holds flit_out, flit_port and the mask stable.
REQ-031 Throughput: one flit per cycle while out_ready = 1 and the buffer is non-empty; a quad with n valid lanes drains in n cycles.

Reset
REQ-032 While rst = 1 at a rising edge: pointers = 0, occupancy = 0, all masks = 0, in_ready = 1, out_valid = 0, flit_out = 0, flit_port = 0.
REQ-033 rst takes priority over push and pop in the same edge; buffered contents are discarded, including a partially drained head quad.
REQ-034 Flit storage data does not require reset; only masks and pointers determine validity.

Verification
REQ-035 Single quad: push N=0x001, S=0x002, E=0x003, W=0x004 with lane_vld=4'hF and out_ready=1 -> flits 0x001/0, 0x002/1, 0x003/2, 0x004/3 on four consecutive cycles starting one cycle after the push; occupancy returns to 0.
REQ-036 Sparse lanes: lane_vld=4'b1010, S=0x155, W=0x2AA -> exactly two transfers, 0x155/port 1 then 0x2AA/port 3; a quad with lane_vld=0 produces no output and occupancy stays 0.
REQ-037 Full/backpressure: out_ready=0 with 4 quads offered back-to-back -> 3 accepted, in_ready=0 and occupancy=3 thereafter; the 4th quad is held until out_ready=1 frees an entry; order is preserved across pointer wrap.
REQ-038 Concurrent push and pop at occupancy=1 on the final lane of the head -> occupancy remains 1 and the next quad's first lane follows without a bubble.
REQ-039 Reset mid-drain: rst=1 after 2 of 4 flits of the head quad are sent, with 2 quads queued -> next cycle out_valid=0, occupancy=0, in_ready=1, flit_out=0; a new quad afterwards drains normally.
